// File: rtl/imm_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_decode_stage : LEGv8 format classify + immediate extend, skid-buffered |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module imm_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [63:0]      out_imm,
  output logic [2:0]       out_fmt,
  output logic [CNT_W-1:0] unk_count
);

  localparam logic [2:0] c_fmt_r  = 3'd0;
  localparam logic [2:0] c_fmt_i  = 3'd1;
  localparam logic [2:0] c_fmt_d  = 3'd2;
  localparam logic [2:0] c_fmt_b  = 3'd3;
  localparam logic [2:0] c_fmt_cb = 3'd4;
  localparam logic [2:0] c_fmt_iw = 3'd5;

  logic [2:0]       w_fmt;
  logic [63:0]      w_imm;
  logic             w_unk;
  logic             w_accept;
  logic             w_out_free;

  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic [63:0]      r_out_imm;
  logic [2:0]       r_out_fmt;
  logic             r_skid_valid;
  logic [31:0]      r_skid_instr;
  logic [63:0]      r_skid_imm;
  logic [2:0]       r_skid_fmt;
  logic [CNT_W-1:0] r_unk_count;

  // Priority order matters: earlier, shorter opcodes shadow later ones.
  always_comb begin
    w_fmt = c_fmt_r;
    w_imm = '0;
    w_unk = 1'b0;
    if (in_instr[31:26] == 6'b000101 || in_instr[31:26] == 6'b100101) begin
      w_fmt = c_fmt_b;
      w_imm = {{38{in_instr[25]}}, in_instr[25:0]};
    end else if (in_instr[31:24] == 8'hB4 || in_instr[31:24] == 8'hB5 ||
                 in_instr[31:24] == 8'h54) begin
      w_fmt = c_fmt_cb;
      w_imm = {{45{in_instr[23]}}, in_instr[23:5]};
    end else if (in_instr[31:23] == 9'b110100101) begin
      w_fmt = c_fmt_iw;
      w_imm = {48'd0, in_instr[20:5]} << {in_instr[22:21], 4'b0000};
    end else if (in_instr[31:22] == 10'b1001000100 ||
                 in_instr[31:22] == 10'b1101000100) begin
      w_fmt = c_fmt_i;
      w_imm = {52'd0, in_instr[21:10]};
    end else if (in_instr[31:21] == 11'b11111000010 ||
                 in_instr[31:21] == 11'b11111000000) begin
      w_fmt = c_fmt_d;
      w_imm = {{55{in_instr[20]}}, in_instr[20:12]};
    end else if (in_instr[31:21] == 11'b10001011000 || in_instr[31:21] == 11'b11001011000 ||
                 in_instr[31:21] == 11'b10001010000 || in_instr[31:21] == 11'b10101010000) begin
      w_fmt = c_fmt_r;
    end else begin
      w_unk = 1'b1;
    end
  end

  assign w_accept   = in_valid & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_imm    <= '0;
      r_out_fmt    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_imm   <= '0;
      r_skid_fmt   <= '0;
      r_unk_count  <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_instr  <= r_skid_instr;
          r_out_imm    <= r_skid_imm;
          r_out_fmt    <= r_skid_fmt;
          r_skid_valid <= w_accept;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) begin
            r_out_instr <= in_instr;
            r_out_imm   <= w_imm;
            r_out_fmt   <= w_fmt;
          end
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
      end
      // Skid payload captures any accept that the output register cannot take.
      if (w_accept && (r_skid_valid || !w_out_free)) begin
        r_skid_instr <= in_instr;
        r_skid_imm   <= w_imm;
        r_skid_fmt   <= w_fmt;
      end
      if (w_accept && w_unk && r_unk_count != {CNT_W{1'b1}}) begin
        r_unk_count <= r_unk_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_imm   = r_out_imm;
  assign out_fmt   = r_out_fmt;
  assign unk_count = r_unk_count;

endmodule
`default_nettype wire
